// File: rtl/regbank_pkg.sv
// Shared defaults and FSM state type for the register bank store.
package regbank_pkg;

  localparam int unsigned     REGBANK_DATA_W     = 16;
  localparam int unsigned     REGBANK_ADDR_W     = 4;
  localparam logic [3:0]      REGBANK_BURST_BASE = 4'b1000;
  localparam int unsigned     REGBANK_BURST_LEN  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

endpackage : regbank_pkg

// File: rtl/regbank_mem.sv
// Row storage with synchronous write and a registered, write-first read port.
module regbank_mem
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W = REGBANK_DATA_W,
  parameter int unsigned ADDR_W = REGBANK_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array is built from flops with a reset because every row must
  // read back as zero after reset; a RAM macro could not honour that.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write to the row being read wins over the stored value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule : regbank_mem

// File: rtl/register_bank_store.sv
// Register bank that stores controller rows and tracks gapless store bursts
// to rows BURST_BASE..BURST_BASE+BURST_LEN-1, flagging sequence errors.
module register_bank_store
  import regbank_pkg::*;
#(
  parameter int unsigned             DATA_W     = REGBANK_DATA_W,
  parameter int unsigned             ADDR_W     = REGBANK_ADDR_W,
  parameter logic [ADDR_W-1:0]       BURST_BASE = ADDR_W'(REGBANK_BURST_BASE),
  parameter int unsigned             BURST_LEN  = REGBANK_BURST_LEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              writemem,
  input  logic [ADDR_W-1:0] rowaddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              burst_active,
  output logic              burst_done,
  output logic              seq_err,
  input  logic              err_clr,
  output logic [7:0]        burst_count
);

  localparam logic [1:0] LAST_OFF = 2'(BURST_LEN - 1);

  burst_state_e      state, state_nxt;
  logic [1:0]        exp, exp_nxt;
  logic [ADDR_W-1:0] exp_row;
  logic              hit_base, hit_exp, at_last;
  logic              done_set, err_set;

  regbank_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (writemem),
    .waddr (rowaddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign exp_row  = BURST_BASE + ADDR_W'(exp);
  assign hit_base = writemem && (rowaddr == BURST_BASE);
  assign hit_exp  = writemem && (rowaddr == exp_row);
  assign at_last  = (exp == LAST_OFF);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, whatever the block order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      exp   <= '0;
    end else begin
      state <= state_nxt;
      exp   <= exp_nxt;
    end
  end

  // NOTE: defaults at the top keep every path assigned, so no latch appears.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp;
    case (state)
      ST_IDLE: begin
        if (hit_base) begin
          state_nxt = ST_BURST;
          exp_nxt   = 2'd1;
        end
      end
      ST_BURST: begin
        if (hit_exp && !at_last) begin
          exp_nxt = exp + 2'd1;
        end else if (hit_base) begin
          // Wrong row that happens to be the base row restarts the burst.
          state_nxt = ST_BURST;
          exp_nxt   = 2'd1;
        end else begin
          // Completion, a gap, or a stray row all end the burst.
          state_nxt = ST_IDLE;
          exp_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        exp_nxt   = 2'd0;
      end
    endcase
  end

  always_comb begin
    done_set = 1'b0;
    err_set  = 1'b0;
    if (state == ST_BURST) begin
      done_set = hit_exp && at_last;
      err_set  = !hit_exp;
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      burst_done  <= 1'b0;
      seq_err     <= 1'b0;
      burst_count <= '0;
    end else begin
      burst_done  <= done_set;
      seq_err     <= err_set | (seq_err & ~err_clr);
      burst_count <= burst_count + 8'(done_set);
    end
  end

  assign burst_active = (state == ST_BURST);

endmodule : register_bank_store
